// File: rtl/terrain_scroller_if.sv
// Bus between terrain_scroller and its height RAM / frame-control neighbours.
// Master side is the scroller; slave side is the RAM plus start/done consumers.
interface terrain_scroller_if #(
  parameter int ADDR_W = 10,
  parameter int Y_W    = 9
) ();
  logic              start;
  logic [Y_W-1:0]    ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [Y_W-1:0]    ram_data;
  logic              busy;
  logic              done;
  logic [Y_W-1:0]    height_last;

  modport master (
    input  start, ram_q,
    output ram_addr, ram_wren, ram_data, busy, done, height_last
  );

  modport slave (
    output start, ram_q,
    input  ram_addr, ram_wren, ram_data, busy, done, height_last
  );
endinterface

// File: rtl/terrain_scroller.sv
// Column-scroll engine: shifts the height RAM SHIFT columns toward 0, then refills the top with a clamped random walk.
// Optional macro TERRAIN_SCROLLER_PAUSE_EN adds a 'pause' input that stalls RD/GEN.
module terrain_scroller #(
  parameter int          ADDR_W = 10,
  parameter int          DEPTH  = 1024,
  parameter int          Y_W    = 9,
  parameter int          SHIFT  = 1,
  parameter int          Y_MIN  = 40,
  parameter int          Y_MAX  = 440,
  parameter int          Y_INIT = 240,
  parameter int          STEP_Y = 4,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic clock,
  input  logic reset,
`ifdef TERRAIN_SCROLLER_PAUSE_EN
  input  logic pause,
`endif
  terrain_scroller_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_GEN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDR_W-1:0] SHIFT_A   = ADDR_W'(SHIFT);
  localparam logic [ADDR_W-1:0] LAST_COPY = ADDR_W'(DEPTH - SHIFT - 1);
  localparam logic [ADDR_W-1:0] FIRST_GEN = ADDR_W'(DEPTH - SHIFT);
  localparam logic [ADDR_W-1:0] LAST_GEN  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  localparam logic [Y_W:0]   Y_MIN_W  = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W:0]   Y_MAX_W  = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0]   STEP_W   = (Y_W+1)'(STEP_Y);
  localparam logic [Y_W-1:0] Y_MIN_N  = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] Y_MAX_N  = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] STEP_N   = Y_W'(STEP_Y);
  localparam logic [Y_W-1:0] Y_INIT_N = Y_W'(Y_INIT);

  logic [2:0]        state;
  logic [ADDR_W-1:0] dst;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;
  logic [Y_W-1:0]    height_r;
  logic [Y_W-1:0]    h_next;
  logic [Y_W:0]      h_wide;
  logic [Y_W:0]      h_up;
  logic              stall;

`ifdef TERRAIN_SCROLLER_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign h_wide    = {1'b0, height_r};
  assign h_up      = h_wide + STEP_W;

  // Saturating random walk; comparisons run one bit wider so nothing wraps
  always_comb begin
    h_next = height_r;
    case (lfsr[1:0])
      2'b00:   h_next = (h_wide < Y_MIN_W + STEP_W) ? Y_MIN_N : height_r - STEP_N;
      2'b11:   h_next = (h_up > Y_MAX_W) ? Y_MAX_N : h_up[Y_W-1:0];
      default: h_next = height_r;
    endcase
  end

  always_comb begin
    bus.ram_addr = '0;
    bus.ram_wren = 1'b0;
    bus.ram_data = '0;
    case (state)
      S_RD:  bus.ram_addr = dst + SHIFT_A;
      S_WR: begin
        bus.ram_addr = dst;
        bus.ram_wren = 1'b1;
        bus.ram_data = bus.ram_q;
      end
      S_GEN: begin
        bus.ram_addr = dst;
        bus.ram_wren = !stall;
        bus.ram_data = h_next;
      end
      default: ;
    endcase
  end

  assign bus.busy        = (state == S_RD) || (state == S_WR) || (state == S_GEN);
  assign bus.done        = (state == S_DONE);
  assign bus.height_last = height_r;

  // Read/write pairs copy the body, then GEN fills the vacated top columns
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      dst      <= '0;
      lfsr     <= SEED;
      height_r <= Y_INIT_N;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_RD;
            dst   <= '0;
          end
        end
        S_RD: begin
          if (!stall) state <= S_WR;
        end
        S_WR: begin
          if (dst == LAST_COPY) begin
            state <= S_GEN;
            dst   <= FIRST_GEN;
          end else begin
            state <= S_RD;
            dst   <= dst + ONE_A;
          end
        end
        S_GEN: begin
          if (!stall) begin
            height_r <= h_next;
            lfsr     <= lfsr_next;
            if (dst == LAST_GEN) state <= S_DONE;
            else                 dst   <= dst + ONE_A;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_terrain_scroller.sv
// Directed bench for terrain_scroller: small 8-column engine with a RAM model, saturation engines and a full-size engine.
// Pause checks compile only when TERRAIN_SCROLLER_PAUSE_EN is defined.
module tb_terrain_scroller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rst_d = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clock = ~clock;

  terrain_scroller_if bus_m ();
  terrain_scroller_if bus_d ();
  terrain_scroller_if bus_h ();
  terrain_scroller_if bus_l ();

`ifdef TERRAIN_SCROLLER_PAUSE_EN
  logic pause = 1'b0;
  logic pause_run = 1'b0;
  logic pause_zero = 1'b0;
`endif

  terrain_scroller #(.DEPTH(8), .SHIFT(2)) dut_m (
    .clock(clock), .reset(reset),
`ifdef TERRAIN_SCROLLER_PAUSE_EN
    .pause(pause),
`endif
    .bus(bus_m)
  );

  terrain_scroller dut_d (
    .clock(clock), .reset(rst_d),
`ifdef TERRAIN_SCROLLER_PAUSE_EN
    .pause(pause_zero),
`endif
    .bus(bus_d)
  );

  terrain_scroller #(.DEPTH(4), .SHIFT(1), .Y_INIT(440), .SEED(16'h0003)) dut_h (
    .clock(clock), .reset(reset),
`ifdef TERRAIN_SCROLLER_PAUSE_EN
    .pause(pause_zero),
`endif
    .bus(bus_h)
  );

  terrain_scroller #(.DEPTH(4), .SHIFT(1), .Y_INIT(40), .SEED(16'h0004)) dut_l (
    .clock(clock), .reset(reset),
`ifdef TERRAIN_SCROLLER_PAUSE_EN
    .pause(pause_zero),
`endif
    .bus(bus_l)
  );

  // Single-port read-first RAM behind the small engine
  logic [8:0] mem [8];
  int writes_m = 0;
  int dones_m = 0;
  always @(posedge clock) begin
    if (bus_m.ram_wren) begin
      mem[bus_m.ram_addr[2:0]] <= bus_m.ram_data;
      writes_m++;
    end
    if (bus_m.done) dones_m++;
    bus_m.ram_q <= mem[bus_m.ram_addr[2:0]];
  end

  assign bus_d.ram_q = '0;
  assign bus_h.ram_q = '0;
  assign bus_l.ram_q = '0;

  int gen_d [$];
  always @(posedge clock) begin
    if (bus_d.ram_wren && bus_d.ram_addr == 10'd1023) gen_d.push_back(int'(bus_d.ram_data));
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0: bus_m.start = v;
      1: bus_d.start = v;
      default: begin
        bus_h.start = v;
        bus_l.start = v;
      end
    endcase
  endtask

  function automatic logic get_busy(input int which);
    case (which)
      0:       return bus_m.busy;
      1:       return bus_d.busy;
      default: return bus_h.busy;
    endcase
  endfunction

  function automatic logic get_done(input int which);
    case (which)
      0:       return bus_m.done;
      1:       return bus_d.done;
      default: return bus_h.done;
    endcase
  endfunction

  // Launches one scroll and counts busy cycles and the cycle of done, relative to the start edge
  task automatic applyStimulus(input int which, input bit hold, input int limit,
                               output int busy_cycles, output int done_cycle);
    @(negedge clock);
    set_start(which, 1'b1);
    @(posedge clock);
    #1;
    if (!hold) set_start(which, 1'b0);
    busy_cycles = 0;
    done_cycle  = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clock);
`ifdef TERRAIN_SCROLLER_PAUSE_EN
      if (which == 0) pause = pause_run && (c >= 3) && (c < 13);
`endif
      if (get_busy(which)) busy_cycles++;
      if (get_done(which)) begin
        done_cycle = c;
        break;
      end
    end
    set_start(which, 1'b0);
`ifdef TERRAIN_SCROLLER_PAUSE_EN
    pause = 1'b0;
`endif
  endtask

  int busy_n;
  int done_n;
  int exp1 [8] = '{2, 3, 4, 5, 6, 7, 240, 244};
  int exp2 [8] = '{4, 5, 6, 7, 240, 244, 248, 252};
`ifdef TERRAIN_SCROLLER_PAUSE_EN
  int exp3 [8] = '{6, 7, 240, 244, 248, 252, 252, 248};
`endif

  initial begin
    set_start(0, 1'b0);
    set_start(1, 1'b0);
    set_start(2, 1'b0);
    for (int i = 0; i < 8; i++) mem[i] = 9'(i);

    repeat (3) @(negedge clock);
    checkOutput("rst_addr", int'(bus_m.ram_addr), 0);
    checkOutput("rst_wren", int'(bus_m.ram_wren), 0);
    checkOutput("rst_data", int'(bus_m.ram_data), 0);
    checkOutput("rst_busy", int'(bus_m.busy), 0);
    checkOutput("rst_done", int'(bus_m.done), 0);
    checkOutput("rst_height", int'(bus_m.height_last), 240);
    reset = 1'b0;
    rst_d = 1'b0;
    @(negedge clock);
    checkOutput("idle_busy", int'(bus_m.busy), 0);

    $display("[TB] scroll 1 of 8-column engine");
    applyStimulus(0, 1'b0, 100, busy_n, done_n);
    checkOutput("s1_busy_cycles", busy_n, 14);
    checkOutput("s1_done_cycle", done_n, 15);
    @(negedge clock);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("s1_ram%0d", i), int'(mem[i]), exp1[i]);
    checkOutput("s1_height", int'(bus_m.height_last), 244);
    checkOutput("s1_writes", writes_m, 8);
    checkOutput("s1_dones", dones_m, 1);

    $display("[TB] scroll 2 with start held through busy");
    applyStimulus(0, 1'b1, 100, busy_n, done_n);
    checkOutput("s2_busy_cycles", busy_n, 14);
    checkOutput("s2_done_cycle", done_n, 15);
    repeat (5) @(negedge clock);
    checkOutput("s2_idle_busy", int'(bus_m.busy), 0);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("s2_ram%0d", i), int'(mem[i]), exp2[i]);
    checkOutput("s2_height", int'(bus_m.height_last), 252);
    checkOutput("s2_writes", writes_m, 16);
    checkOutput("s2_dones", dones_m, 2);

`ifdef TERRAIN_SCROLLER_PAUSE_EN
    $display("[TB] scroll 3 with 10 paused cycles");
    pause_run = 1'b1;
    applyStimulus(0, 1'b0, 100, busy_n, done_n);
    pause_run = 1'b0;
    checkOutput("s3_busy_cycles", busy_n, 24);
    checkOutput("s3_done_cycle", done_n, 25);
    @(negedge clock);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("s3_ram%0d", i), int'(mem[i]), exp3[i]);
    checkOutput("s3_height", int'(bus_m.height_last), 248);
    checkOutput("s3_writes", writes_m, 24);
`endif

    $display("[TB] saturation engines");
    applyStimulus(2, 1'b0, 50, busy_n, done_n);
    checkOutput("sat_busy_cycles", busy_n, 7);
    checkOutput("sat_done_cycle", done_n, 8);
    checkOutput("sat_high", int'(bus_h.height_last), 440);
    checkOutput("sat_low", int'(bus_l.height_last), 40);

    $display("[TB] full-size engine, two scrolls");
    applyStimulus(1, 1'b0, 2100, busy_n, done_n);
    checkOutput("d1_busy_cycles", busy_n, 2047);
    checkOutput("d1_done_cycle", done_n, 2048);
    applyStimulus(1, 1'b0, 2100, busy_n, done_n);
    checkOutput("d2_busy_cycles", busy_n, 2047);
    checkOutput("d2_done_cycle", done_n, 2048);
    checkOutput("d_gen_count", gen_d.size(), 2);
    if (gen_d.size() >= 2) begin
      checkOutput("d_gen0", gen_d[0], 240);
      checkOutput("d_gen1", gen_d[1], 244);
    end
    checkOutput("d_height", int'(bus_d.height_last), 244);

    $display("[TB] reset at cycle 500 of a scroll");
    @(negedge clock);
    bus_d.start = 1'b1;
    @(posedge clock);
    #1 bus_d.start = 1'b0;
    repeat (500) @(negedge clock);
    checkOutput("mid_busy", int'(bus_d.busy), 1);
    rst_d = 1'b1;
    #1;
    checkOutput("abort_wren", int'(bus_d.ram_wren), 0);
    checkOutput("abort_busy", int'(bus_d.busy), 0);
    checkOutput("abort_height", int'(bus_d.height_last), 240);
    @(negedge clock);
    rst_d = 1'b0;
    applyStimulus(1, 1'b0, 2100, busy_n, done_n);
    checkOutput("d3_busy_cycles", busy_n, 2047);
    checkOutput("d3_done_cycle", done_n, 2048);
    checkOutput("d3_gen_count", gen_d.size(), 3);
    if (gen_d.size() >= 3) checkOutput("d3_gen", gen_d[2], 240);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
